// File: rtl/mcs4_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcs4_timing_pkg
// Brief    : Shared phase encoding and defaults for the MCS-4 bus timing block
// Revision : 1.0 - initial release
// ============================================================================
package mcs4_timing_pkg;

    localparam int PHASE_W    = 3;
    localparam int NUM_PHASES = 8;

    localparam logic [PHASE_W-1:0] PH_A1 = 3'd0;
    localparam logic [PHASE_W-1:0] PH_A2 = 3'd1;
    localparam logic [PHASE_W-1:0] PH_A3 = 3'd2;
    localparam logic [PHASE_W-1:0] PH_M1 = 3'd3;
    localparam logic [PHASE_W-1:0] PH_M2 = 3'd4;
    localparam logic [PHASE_W-1:0] PH_X1 = 3'd5 - 3'd0 - 3'd0;
    localparam logic [PHASE_W-1:0] PH_X2 = 3'd6;
    localparam logic [PHASE_W-1:0] PH_X3 = 3'd7;

    // Bit p set: core drives the bus during phase p (A1..A3 by default)
    localparam logic [NUM_PHASES-1:0] OUT_MASK_DEFAULT = 8'b0000_0111;

    // Bit positions inside cap_strobe
    localparam int CAP_M1 = 0;
    localparam int CAP_M2 = 1;
    localparam int CAP_X2 = 2;

endpackage : mcs4_timing_pkg
`default_nettype wire

// File: rtl/clk_phase_counter.sv
`default_nettype none
// ============================================================================
// Module   : clk_phase_counter
// Brief    : Samples clk1/clk2 pads, detects rise1/fall2, steps the 8-phase
//            counter and flags clock overlap
// Revision : 1.0 - initial release
// ============================================================================
module clk_phase_counter
    import mcs4_timing_pkg::*;
(
    input  logic               sysclk,
    input  logic               poc_pad,
    input  logic               i_clk1_pad,
    input  logic               i_clk2_pad,
    output logic               o_rise1,
    output logic               o_fall2,
    output logic [PHASE_W-1:0] o_phase,
    output logic [PHASE_W-1:0] o_phase_next,
    output logic               o_clk_err
);

    logic               clk1_q;
    logic               clk2_q;
    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;
    logic               clk_err_q;
    logic               clk_err_d;
    logic               w_overlap;
    logic               w_rise1;
    logic               w_fall2;
    logic [PHASE_W-1:0] w_phase_next;

    always_comb begin
        w_overlap    = i_clk1_pad & i_clk2_pad;
        // An overlapping clk1 edge is discarded, not deferred
        w_rise1      = i_clk1_pad & ~clk1_q & ~w_overlap;
        w_fall2      = clk2_q & ~i_clk2_pad;
        w_phase_next = phase_q + 3'd1;
        phase_d      = w_rise1 ? w_phase_next : phase_q;
        clk_err_d    = clk_err_q | w_overlap;
    end

    always_ff @(posedge sysclk or posedge poc_pad) begin
        if (poc_pad) begin
            clk1_q    <= 1'b0;
            clk2_q    <= 1'b0;
            phase_q   <= PH_X3;
            clk_err_q <= 1'b0;
        end else begin
            clk1_q    <= i_clk1_pad;
            clk2_q    <= i_clk2_pad;
            phase_q   <= phase_d;
            clk_err_q <= clk_err_d;
        end
    end

    assign o_rise1      = w_rise1;
    assign o_fall2      = w_fall2;
    assign o_phase      = phase_q;
    assign o_phase_next = w_phase_next;
    assign o_clk_err    = clk_err_q;

endmodule : clk_phase_counter
`default_nettype wire

// File: rtl/bus_phase_io.sv
`default_nettype none
// ============================================================================
// Module   : bus_phase_io
// Brief    : MCS-4 timing / I-O pad block: phase sequencing, split data bus
//            drive and capture, CM strobes, POC and synchronised TEST
// Revision : 1.0 - initial release
// ============================================================================
module bus_phase_io
    import mcs4_timing_pkg::*;
#(
    parameter int                      DATA_W      = 4,
    parameter int                      NUM_CM      = 4,
    parameter logic [NUM_PHASES-1:0]   OUT_MASK    = OUT_MASK_DEFAULT,
    parameter int                      SYNC_STAGES = 2
) (
    input  logic                sysclk,
    input  logic                poc_pad,
    input  logic                clk1_pad,
    input  logic                clk2_pad,
    input  logic                test_pad,
    input  logic                ior,
    input  logic [DATA_W-1:0]   core_dout,
    input  logic                cm_req,
    input  logic [NUM_CM-1:0]   cm_sel,
    input  logic [DATA_W-1:0]   data_pad_i,
    output logic [DATA_W-1:0]   data_pad_o,
    output logic                data_pad_oe,
    output logic [PHASE_W-1:0]  phase,
    output logic                sync_pad,
    output logic                poc,
    output logic                test_n,
    output logic                cmrom_pad,
    output logic [NUM_CM-1:0]   cmram_pad,
    output logic [DATA_W-1:0]   m1_data,
    output logic [DATA_W-1:0]   m2_data,
    output logic [DATA_W-1:0]   x2_data,
    output logic [2:0]          cap_strobe,
    output logic                clk_err
);

    logic               w_rise1;
    logic               w_fall2;
    logic [PHASE_W-1:0] w_phase;
    logic [PHASE_W-1:0] w_phase_next;
    logic [NUM_CM-1:0]  w_cm_onehot;
    logic               w_cmd;

    logic                   poc_q,    poc_d;
    logic                   oe_q,     oe_d;
    logic [DATA_W-1:0]      dout_q,   dout_d;
    logic [DATA_W-1:0]      m1_q,     m1_d;
    logic [DATA_W-1:0]      m2_q,     m2_d;
    logic [DATA_W-1:0]      x2_q,     x2_d;
    logic [2:0]             cap_q,    cap_d;
    logic                   cmrom_q,  cmrom_d;
    logic [NUM_CM-1:0]      cmram_q,  cmram_d;
    logic [SYNC_STAGES-1:0] sync_q,   sync_d;

    clk_phase_counter u_clk_phase_counter (
        .sysclk       (sysclk),
        .poc_pad      (poc_pad),
        .i_clk1_pad   (clk1_pad),
        .i_clk2_pad   (clk2_pad),
        .o_rise1      (w_rise1),
        .o_fall2      (w_fall2),
        .o_phase      (w_phase),
        .o_phase_next (w_phase_next),
        .o_clk_err    (clk_err)
    );

    always_comb begin
        poc_d   = poc_q;
        oe_d    = oe_q;
        dout_d  = dout_q;
        m1_d    = m1_q;
        m2_d    = m2_q;
        x2_d    = x2_q;
        cap_d   = 3'b000;
        cmrom_d = cmrom_q;
        cmram_d = cmram_q;
        w_cmd   = 1'b0;

        // Isolate the lowest set bit of the bank select
        w_cm_onehot = cm_sel & (~cm_sel + NUM_CM'(1));

        // Phase-entry outputs use the post-edge POC so A1 already drives data
        if (w_rise1) begin
            poc_d   = poc_q & (w_phase_next != PH_A1);
            oe_d    = poc_d | OUT_MASK[w_phase_next] | ((w_phase_next == PH_X2) & ~ior);
            dout_d  = poc_d ? '0 : core_dout;
            w_cmd   = ~poc_d & ((w_phase_next == PH_A3) | ((w_phase_next == PH_X2) & cm_req));
            cmrom_d = w_cmd;
            cmram_d = w_cmd ? w_cm_onehot : '0;
        end

        if (w_fall2 & ~poc_q & ~oe_q) begin
            case (w_phase)
                PH_M1: begin
                    m1_d          = data_pad_i;
                    cap_d[CAP_M1] = 1'b1;
                end
                PH_M2: begin
                    m2_d          = data_pad_i;
                    cap_d[CAP_M2] = 1'b1;
                end
                PH_X2: begin
                    x2_d          = data_pad_i;
                    cap_d[CAP_X2] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
        if (i == 0) begin : g_first
            assign sync_d[i] = ~test_pad;
        end else begin : g_next
            assign sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge sysclk or posedge poc_pad) begin
        if (poc_pad) begin
            poc_q   <= 1'b1;
            oe_q    <= 1'b1;
            dout_q  <= '0;
            m1_q    <= '0;
            m2_q    <= '0;
            x2_q    <= '0;
            cap_q   <= 3'b000;
            cmrom_q <= 1'b0;
            cmram_q <= '0;
            sync_q  <= '0;
        end else begin
            poc_q   <= poc_d;
            oe_q    <= oe_d;
            dout_q  <= dout_d;
            m1_q    <= m1_d;
            m2_q    <= m2_d;
            x2_q    <= x2_d;
            cap_q   <= cap_d;
            cmrom_q <= cmrom_d;
            cmram_q <= cmram_d;
            sync_q  <= sync_d;
        end
    end

    assign phase       = w_phase;
    assign sync_pad    = (w_phase == PH_X3);
    assign poc         = poc_q;
    assign data_pad_oe = oe_q;
    assign data_pad_o  = dout_q;
    assign m1_data     = m1_q;
    assign m2_data     = m2_q;
    assign x2_data     = x2_q;
    assign cap_strobe  = cap_q;
    assign cmrom_pad   = cmrom_q;
    assign cmram_pad   = cmram_q;
    assign test_n      = sync_q[SYNC_STAGES-1];

endmodule : bus_phase_io
`default_nettype wire

// File: tb/tb_bus_phase_io.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_phase_io
// Brief    : Randomised self-checking bench for bus_phase_io against a
//            phase-level behavioural model
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_phase_io;

    localparam int         DATA_W      = 4;
    localparam int         NUM_CM      = 4;
    localparam int         SYNC_STAGES = 2;
    localparam logic [7:0] C_OUT_MASK  = 8'b0000_0111;

    logic              sysclk = 1'b0;
    logic              poc_pad, clk1_pad, clk2_pad, test_pad, ior, cm_req;
    logic [DATA_W-1:0] core_dout, data_pad_i;
    logic [NUM_CM-1:0] cm_sel;
    logic [DATA_W-1:0] data_pad_o, m1_data, m2_data, x2_data;
    logic              data_pad_oe, sync_pad, poc, test_n, cmrom_pad, clk_err;
    logic [2:0]        phase, cap_strobe;
    logic [NUM_CM-1:0] cmram_pad;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int                m_phase;
    bit                m_poc, m_oe, m_cmrom, m_err, m_testn;
    logic [DATA_W-1:0] m_do, m_m1, m_m2, m_x2;
    logic [NUM_CM-1:0] m_cmram;
    logic [2:0]        m_strobe;
    bit                rand_mode = 1'b0;
    logic [7:0]        out_mask = C_OUT_MASK;

    bus_phase_io #(
        .DATA_W      (DATA_W),
        .NUM_CM      (NUM_CM),
        .OUT_MASK    (C_OUT_MASK),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .sysclk      (sysclk),
        .poc_pad     (poc_pad),
        .clk1_pad    (clk1_pad),
        .clk2_pad    (clk2_pad),
        .test_pad    (test_pad),
        .ior         (ior),
        .core_dout   (core_dout),
        .cm_req      (cm_req),
        .cm_sel      (cm_sel),
        .data_pad_i  (data_pad_i),
        .data_pad_o  (data_pad_o),
        .data_pad_oe (data_pad_oe),
        .phase       (phase),
        .sync_pad    (sync_pad),
        .poc         (poc),
        .test_n      (test_n),
        .cmrom_pad   (cmrom_pad),
        .cmram_pad   (cmram_pad),
        .m1_data     (m1_data),
        .m2_data     (m2_data),
        .x2_data     (x2_data),
        .cap_strobe  (cap_strobe),
        .clk_err     (clk_err)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    function automatic logic [NUM_CM-1:0] lowest(input logic [NUM_CM-1:0] s);
        logic [NUM_CM-1:0] r;
        r = '0;
        for (int i = NUM_CM - 1; i >= 0; i--)
            if (s[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        return r;
    endfunction

    task automatic model_reset();
        m_phase = 7; m_poc = 1; m_oe = 1; m_do = '0;
        m_m1 = '0; m_m2 = '0; m_x2 = '0; m_strobe = '0;
        m_cmrom = 0; m_cmram = '0; m_err = 0; m_testn = 0;
    endtask

    task automatic model_rise();
        bit cmd;
        m_phase = (m_phase + 1) % 8;
        if (m_phase == 0) m_poc = 0;
        m_oe     = m_poc || out_mask[m_phase] || (m_phase == 6 && !ior);
        m_do     = m_poc ? '0 : core_dout;
        cmd      = !m_poc && (m_phase == 2 || (m_phase == 6 && cm_req));
        m_cmrom  = cmd;
        m_cmram  = cmd ? lowest(cm_sel) : '0;
        m_strobe = '0;
    endtask

    task automatic model_fall(input logic [DATA_W-1:0] din);
        m_strobe = '0;
        if (!m_poc && !m_oe) begin
            if (m_phase == 3) begin m_m1 = din; m_strobe = 3'b001; end
            if (m_phase == 4) begin m_m2 = din; m_strobe = 3'b010; end
            if (m_phase == 6) begin m_x2 = din; m_strobe = 3'b100; end
        end
    endtask

    task automatic check_all();
        check("phase",      32'(phase),       32'(m_phase));
        check("sync_pad",   32'(sync_pad),    32'(m_phase == 7));
        check("poc",        32'(poc),         32'(m_poc));
        check("oe",         32'(data_pad_oe), 32'(m_oe));
        check("data_pad_o", 32'(data_pad_o),  32'(m_do));
        check("m1_data",    32'(m1_data),     32'(m_m1));
        check("m2_data",    32'(m2_data),     32'(m_m2));
        check("x2_data",    32'(x2_data),     32'(m_x2));
        check("cap_strobe", 32'(cap_strobe),  32'(m_strobe));
        check("cmrom_pad",  32'(cmrom_pad),   32'(m_cmrom));
        check("cmram_pad",  32'(cmram_pad),   32'(m_cmram));
        check("clk_err",    32'(clk_err),     32'(m_err));
        check("test_n",     32'(test_n),      32'(m_testn));
    endtask

    // One phase: clk1 pulse (2 cycles), gap, clk2 pulse (2 cycles), gap
    task automatic run_phase(input logic [DATA_W-1:0] din);
        clk1_pad = 1'b1; tick(); model_rise(); check_all();
        tick(); check_all();
        clk1_pad = 1'b0; tick(); check_all();
        clk2_pad = 1'b1; data_pad_i = din; tick(); check_all();
        tick(); check_all();
        clk2_pad = 1'b0; tick(); model_fall(din); check_all();
        tick(); m_strobe = '0; check_all();
    endtask

    task automatic run_cycle(input logic [DATA_W-1:0] m1v, input logic [DATA_W-1:0] x2v);
        int nxt;
        for (int k = 0; k < 8; k++) begin
            nxt = (m_phase + 1) % 8;
            if (rand_mode) begin
                core_dout = DATA_W'($urandom);
                ior       = 1'($urandom_range(0, 1));
                cm_req    = 1'($urandom_range(0, 1));
                cm_sel    = NUM_CM'($urandom);
                run_phase(DATA_W'($urandom));
            end else begin
                run_phase(nxt == 3 ? m1v : (nxt == 6 ? x2v : DATA_W'($urandom)));
            end
        end
    endtask

    initial begin
        poc_pad = 1'b1; clk1_pad = 1'b0; clk2_pad = 1'b0; test_pad = 1'b1;
        ior = 1'b1; core_dout = '0; cm_req = 1'b0; cm_sel = '0; data_pad_i = '0;
        model_reset();
        repeat (3) tick();
        check_all();
        poc_pad = 1'b0;
        tick(); check_all();

        // Directed: first cycle from reset, capture M1=5 and X2=3, commands in A3/X2
        core_dout = 4'hA; ior = 1'b1; cm_req = 1'b1; cm_sel = 4'b0110;
        run_phase(4'h0);
        run_cycle(4'h5, 4'h3);
        // Core drives in X2: no X2 capture, commands only in A3
        ior = 1'b0; cm_req = 1'b0;
        run_cycle(4'h9, 4'hC);
        // Empty and multi-hot bank select
        ior = 1'b1; cm_req = 1'b1; cm_sel = 4'b0000;
        run_cycle(4'h1, 4'h2);
        cm_sel = 4'b1011; core_dout = 4'h6;
        run_cycle(4'hE, 4'h7);

        // Clock overlap during A1: no advance, sticky error
        clk1_pad = 1'b1; clk2_pad = 1'b1; tick(); m_err = 1; check_all();
        clk1_pad = 1'b0; clk2_pad = 1'b0; tick(); model_fall(data_pad_i); check_all();
        tick(); m_strobe = '0; check_all();
        run_cycle(4'h4, 4'h8);

        rand_mode = 1'b1;
        repeat (20) run_cycle('0, '0);
        rand_mode = 1'b0;

        // Advance to M1, enter M2, then pull poc_pad asynchronously
        while (m_phase != 3) run_phase(DATA_W'($urandom));
        clk1_pad = 1'b1; tick(); model_rise(); check_all();
        poc_pad = 1'b1; test_pad = 1'b0; #1;
        model_reset(); check_all();
        clk1_pad = 1'b0; tick(); check_all();
        poc_pad = 1'b0;
        for (int k = 1; k <= SYNC_STAGES + 1; k++) begin
            tick();
            m_testn = (k >= SYNC_STAGES);
            check_all();
        end
        ior = 1'b1; cm_req = 1'b1; cm_sel = 4'b0100; core_dout = 4'h3;
        run_phase(4'h0);
        run_cycle(4'hB, 4'hD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bus_phase_io
`default_nettype wire

// File: doc/bus_phase_io.md
Name: bus_phase_io

Overview:
- Parametrised successor to the 4004 timing/I-O pad block.
- Sequences the 8-phase MCS-4 instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3) from the two-phase clock pads. Runs in the `sysclk` domain.
- Drives and captures a DATA_W-wide split data bus (in / out / oe, no inout).
- Generates CM-ROM plus NUM_CM CM-RAM command strobes, a clean POC and a synchronised ~TEST.
- Sits between the CPU core and the chip pads.

Parameters:
- DATA_W, 4, data bus width.
- NUM_CM, 4, number of CM-RAM command lines.
- OUT_MASK, 8'b0000_0111, bit p=1 means the core drives the bus in phase p (bit0=A1 .. bit7=X3).
- SYNC_STAGES, 2, flop stages on test_pad (minimum 2).

Ports:
- `sysclk` in 1: single system clock, all flops posedge.
- `poc_pad` in 1: reset, asynchronous, active-high.
- `clk1_pad` in 1: phase-1 clock level.
- `clk2_pad` in 1: phase-2 clock level.
- `test_pad` in 1: raw TEST pin.
- `ior` in 1: 1 means X2 is a core read; 0 means the core drives in X2.
- `core_dout` in DATA_W: data the core presents for output.
- `cm_req` in 1: issue the X2 command this cycle.
- `cm_sel` in NUM_CM: CM-RAM bank select.
- `data_pad_i` in DATA_W: pad input.
- `data_pad_o` out DATA_W: pad output value.
- `data_pad_oe` out 1: pad output enable.
- `phase` out 3: current phase index, 0=A1 .. 7=X3.
- `sync_pad` out 1: high throughout X3.
- `poc` out 1: clean power-on-clear.
- `test_n` out 1: synchronised ~test_pad.
- `cmrom_pad` out 1: CM-ROM strobe.
- `cmram_pad` out NUM_CM: CM-RAM strobes.
- `m1_data`, `m2_data`, `x2_data` out DATA_W each: bus values captured in M1, M2 and X2.
- `cap_strobe` out 3: one-cycle pulse per capture. Bit0=M1, bit1=M2, bit2=X2.
- `clk_err` out 1: sticky clock-overlap flag.

Behaviour:
- Reset, asserted asynchronously by poc_pad:
  - phase=7, poc=1, data_pad_oe=1, data_pad_o=0.
  - All capture registers=0, cap_strobe=0, cmrom/cmram=0, clk_err=0, test_n=0, sync_pad=1.
- Clock sampling:
  - clk1_q and clk2_q are registered copies of the pads.
  - rise1 = clk1_pad & ~clk1_q.
  - fall2 = clk2_q & ~clk2_pad.
- Phase advance:
  - On rise1, phase <= phase+1 (mod 8; X3 wraps to A1).
  - If clk1_pad & clk2_pad are high in the same cycle, rise1 is ignored for that cycle and clk_err <= 1 until reset.
- All phase-dependent registered outputs update in the same sysclk edge as phase, so they align with it (zero extra latency).
- sync_pad = (phase==7), combinational from the phase register.
- POC:
  - Remains 1 after poc_pad falls.
  - Clears on the first rise1 that moves phase to A1 while poc_pad=0.
- Bus drive, registered on rise1 for the entered phase p:
  - data_pad_oe <= poc | OUT_MASK[p] | (p==X2 & ~ior).
  - data_pad_o <= poc ? 0 : core_dout.
- Capture:
  - On fall2 in phase M1/M2/X2, with poc=0 and data_pad_oe=0, latch data_pad_i into m1_data/m2_data/x2_data.
  - The matching cap_strobe bit is high for exactly the cycle in which the new value is visible.
  - No capture occurs if oe=1 in that phase.
- Commands, registered on rise1:
  - Entering A3: cmrom_pad <= 1 and cmram_pad <= lowest set bit of cm_sel, sampled at that edge.
  - Entering X2 with cm_req=1: same, using cm_sel sampled then.
  - Otherwise all command strobes are 0.
  - cm_sel=0 gives no RAM strobe. Multi-hot cm_sel drives only the lowest set bit.
  - While poc=1, all command strobes are 0.
- TEST: test_n is ~test_pad through a SYNC_STAGES-deep flop chain, so latency is SYNC_STAGES cycles.
- Reset mid-cycle: all state returns to reset values immediately. The sequence restarts at A1 on the next rise1.

Decomposition:
- Shared package `mcs4_timing_pkg`:
  - PHASE_W=3, NUM_PHASES=8.
  - Localparams PH_A1..PH_X3.
  - Default OUT_MASK constant.
- One sub-module, `clk_phase_counter`: clock sampling, rise1/fall2 detection, phase counter, clk_err.

Test Plan:
- Release poc_pad, then run 9 clean clk1/clk2 periods -> phase steps 0..7 then 0; sync_pad high only in phase 7; poc falls at the first A1.
- core_dout=4'hA, default OUT_MASK, ior=1 -> oe=1 with data_pad_o=A in A1-A3, oe=0 in M1; data_pad_i=5 in M1 -> m1_data=5 and cap_strobe=001 for one cycle at fall2.
- ior=0 in X2, data_pad_i=3 -> oe=1 and x2_data unchanged; ior=1 -> x2_data=3 and cap_strobe=100.
- cm_sel=4'b0110, cm_req=1 -> cmram_pad=0010 and cmrom_pad=1 during A3 and X2; cm_req=0 -> strobes in A3 only; cm_sel=0 -> cmram_pad=0.
- Hold clk1_pad & clk2_pad high for 1 cycle -> phase does not advance and clk_err=1 until poc_pad pulse.
- Assert poc_pad during M2 -> immediate reset values (phase=7, oe=1, data_pad_o=0); test_pad=0 -> test_n=1 after exactly SYNC_STAGES cycles.
